// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage feeding decode. Owns the 8-bit PC and issues reads
//   to a synchronous-read instruction memory (data one cycle after request).
//   It buffers the returned instructions, each tagged with its PC, in a
//   DEPTH-entry FIFO and presents the FIFO head to decode over valid/ready.
//   A redirect (taken jump) flushes the FIFO, drops the read in flight and
//   restarts fetch at the target address on the following cycle.
//
// Parameters
//   DEPTH           FIFO entries, legal range 2..8
//   RESET_PC        PC loaded on reset
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst_n           synchronous active-low reset
//   imem_req        read request to instruction memory this cycle
//   imem_addr       read address, meaningful while imem_req=1
//   imem_rdata      read data, valid exactly one cycle after the request
//   instr           FIFO head instruction (0 when empty)
//   instr_pc        PC of the head instruction (0 when empty)
//   instr_valid     FIFO non-empty
//   instr_ready     decode accepts the head this cycle
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     restart address
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_rdata,
    output logic [7:0] instr,
    output logic [7:0] instr_pc,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       redirect_valid,
    input  logic [7:0] redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    // Occupancy is count + pend, one bit wider than count so it cannot wrap.
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

    // Architectural state
    logic [7:0]    pc_q, pc_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_pc_q, pend_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    // FIFO storage: instruction byte and its PC
    logic [7:0] data_q [DEPTH];
    logic [7:0] tag_q  [DEPTH];

    // Per-cycle events
    logic [CW:0] occ;
    logic        issue;
    logic        enq;
    logic        deq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Output / event logic
    // -----------------------------------------------------------------------
    always_comb begin
        occ = {1'b0, count_q} + {{CW{1'b0}}, pend_q};
        // Counting the in-flight read as occupied guarantees its response
        // always finds a free entry, so the FIFO needs no back-pressure path.
        issue = rst_n & ~redirect_valid & (occ < DEPTH_OCC);
        // A redirect drops the response arriving this cycle.
        enq   = pend_q & ~redirect_valid;

        instr_valid = (count_q != '0);
        deq         = instr_valid & instr_ready;

        imem_req  = issue;
        imem_addr = pc_q;

        // Head is driven from storage only, never straight from imem_rdata.
        instr    = instr_valid ? data_q[rd_ptr_q] : '0;
        instr_pc = instr_valid ? tag_q[rd_ptr_q]  : '0;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;

        if (redirect_valid) begin
            // Redirect outranks everything: a handshake this cycle still
            // counts as accepted by decode, but the buffer is emptied anyway.
            pc_d     = redirect_pc;
            pend_d   = 1'b0;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            pend_d = issue;
            if (issue) begin
                pend_pc_d = pc_q;
                pc_d      = pc_q + 8'd1;
            end
            if (enq) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (deq) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; an entry is only visible
    // once count covers it, and the outputs are forced to 0 when empty.
    always_ff @(posedge clk) begin
        if (enq) begin
            data_q[wr_ptr_q] <= imem_rdata;
            tag_q[wr_ptr_q]  <= pend_pc_q;
        end
    end

    // -----------------------------------------------------------------------
    // Invariants
    // -----------------------------------------------------------------------
    a_no_enq_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        enq |-> (count_q != DEPTH_CNT));

    a_no_pop_when_empty : assert property (@(posedge clk) disable iff (!rst_n)
        (instr_valid & instr_ready) |-> (count_q != '0));

    a_no_req_on_redirect : assert property (@(posedge clk)
        redirect_valid |-> !imem_req);

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit: a synchronous-read instruction memory
//   model, a table of per-cycle vectors for reset / latency / backpressure,
//   hand-written sequences for redirect, PC wrap and mid-run reset, and a
//   randomized run checked against an in-order stream model of the PCs.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int         DEPTH    = 4;
    localparam logic [7:0] RESET_PC = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       redirect_valid;
    logic [7:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Synchronous-read instruction memory; junk on cycles without a request.
    logic [7:0] imem [256];

    always @(posedge clk) begin
        imem_rdata <= imem_req ? imem[imem_addr] : 8'hEE;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs for the current cycle and let combinational outputs settle.
    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [7:0] rpc);
        rst_n          = r;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string name, input logic v, input logic [7:0] pc);
        check({name, "_valid"}, instr_valid, v);
        check({name, "_pc"}, instr_pc, v ? pc : 8'h00);
        check({name, "_instr"}, instr, v ? imem[pc] : 8'h00);
    endtask

    // Per-cycle vector: inputs, then expected outputs. chk=0 checks only imem_req.
    typedef struct {
        logic       rst_n;
        logic       ready;
        logic       chk;
        logic       exp_req;
        logic [7:0] exp_addr;
        logic       exp_valid;
        logic [7:0] exp_instr;
        logic [7:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    // Randomized-run reference state
    logic [7:0] exp_pc;
    logic [7:0] fetch_pc;
    int         issued;
    int         accepted;
    int         total_acc;
    logic       prev_rv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 8'(i + 'h10);

        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();

        // ---- Table: reset, 1/cycle stream (ready=1), then backpressure fill
        //      and drain (ready=0 from reset, raised later).
        //              rst  rdy chk req addr   vld instr  pc
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,8'h00});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,8'h00,1'b0,8'h00,8'h00});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,8'h00,1'b0,8'h00,8'h00});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,8'h01,1'b0,8'h00,8'h00});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,8'h02,1'b1,8'h10,8'h00});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,8'h03,1'b1,8'h11,8'h01});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,8'h04,1'b1,8'h12,8'h02});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,8'h05,1'b1,8'h13,8'h03});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,8'h00});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h00,8'h00});
        vecs.push_back('{1'b1,1'b0,1'b1,1'b1,8'h00,1'b0,8'h00,8'h00});
        vecs.push_back('{1'b1,1'b0,1'b1,1'b1,8'h01,1'b0,8'h00,8'h00});
        vecs.push_back('{1'b1,1'b0,1'b1,1'b1,8'h02,1'b1,8'h10,8'h00});
        vecs.push_back('{1'b1,1'b0,1'b1,1'b1,8'h03,1'b1,8'h10,8'h00});
        vecs.push_back('{1'b1,1'b0,1'b1,1'b0,8'h04,1'b1,8'h10,8'h00});
        vecs.push_back('{1'b1,1'b0,1'b1,1'b0,8'h04,1'b1,8'h10,8'h00});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0,8'h04,1'b1,8'h10,8'h00});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,8'h04,1'b1,8'h11,8'h01});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,8'h05,1'b1,8'h12,8'h02});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,8'h06,1'b1,8'h13,8'h03});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,8'h07,1'b1,8'h14,8'h04});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b1,8'h08,1'b1,8'h15,8'h05});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].ready, 1'b0, 8'h00);
            check($sformatf("vec%0d_req", i), imem_req, vecs[i].exp_req);
            if (vecs[i].chk) begin
                if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_valid", i), instr_valid, vecs[i].exp_valid);
                check($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
                check($sformatf("vec%0d_pc", i), instr_pc, vecs[i].exp_pc);
            end
            tick();
        end

        // ---- Redirect with pend=1 and two entries buffered
        drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
        drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 1'b0, 8'h00); tick();
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00);          // stall once: count grows to 2
        expect_head("redir_pre", 1'b1, 8'h03);
        tick();
        drive(1'b1, 1'b1, 1'b1, 8'h40);
        check("redir_req_low", imem_req, 1'b0);
        expect_head("redir_cyc", 1'b1, 8'h03);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        expect_head("redir_r1", 1'b0, 8'h00);
        check("redir_r1_req", imem_req, 1'b1);
        check("redir_r1_addr", imem_addr, 8'h40);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        expect_head("redir_r2", 1'b0, 8'h00);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        expect_head("redir_r3", 1'b1, 8'h40);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        expect_head("redir_r4", 1'b1, 8'h41);
        tick();

        // ---- Redirect to 8'hFE: PC wraps through 8'hFF to 8'h00
        drive(1'b1, 1'b1, 1'b1, 8'hFE); tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00); tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00); tick();
        for (int k = 0; k < 4; k++) begin
            logic [7:0] want;
            want = 8'hFE + 8'(k);
            drive(1'b1, 1'b1, 1'b0, 8'h00);
            expect_head($sformatf("wrap%0d", k), 1'b1, want);
            tick();
        end

        // ---- Mid-run reset with the buffer nearly full and a read in flight
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00); tick();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("mrst_req_low", imem_req, 1'b0);
        expect_head("mrst_before", 1'b1, 8'h00);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        expect_head("mrst_after", 1'b0, 8'h00);
        check("mrst_addr", imem_addr, RESET_PC);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        expect_head("mrst_c1", 1'b0, 8'h00);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        expect_head("mrst_c2", 1'b1, RESET_PC);
        tick();

        // ---- Randomized: random memory, ready and redirects vs. stream model.
        //      Model: after reset/redirect to T, decode sees T, T+1, T+2, ...
        //      each with imem[pc]; fetch addresses also run T, T+1, ...;
        //      issued-but-unaccepted never exceeds DEPTH.
        for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        exp_pc    = RESET_PC;
        fetch_pc  = RESET_PC;
        issued    = 0;
        accepted  = 0;
        total_acc = 0;
        prev_rv   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic       rdy;
            logic       rv;
            logic [7:0] rpc;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = 8'($urandom);
            drive(1'b1, rdy, rv, rpc);
            if (prev_rv) check("rand_flushed", instr_valid, 1'b0);
            if (instr_valid && rdy) begin
                check("rand_pc", instr_pc, exp_pc);
                check("rand_instr", instr, imem[instr_pc]);
                exp_pc = exp_pc + 8'd1;
                accepted++;
                total_acc++;
            end
            if (rv) begin
                check("rand_req_on_redirect", imem_req, 1'b0);
                exp_pc   = rpc;
                fetch_pc = rpc;
                issued   = 0;
                accepted = 0;
            end else if (imem_req) begin
                check("rand_addr", imem_addr, fetch_pc);
                fetch_pc = fetch_pc + 8'd1;
                issued++;
            end
            check("rand_occupancy", (issued - accepted) <= DEPTH, 1'b1);
            prev_rv = rv;
            tick();
        end
        check("rand_progress", total_acc > 500, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
